// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - execute-stage controller for an external 8-bit combinational ALU
// Owns a 4x8 register file and flag register; one instruction per four cycles.
module alu_exec_ctrl #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_opcode,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic              instr_use_imm,
  input  logic              instr_wb,
  output logic [DATA_W-1:0] alu_operand_1,
  output logic [DATA_W-1:0] alu_operand_2,
  output logic [3:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  input  logic              alu_cy,
  input  logic              alu_sign,
  output logic              flag_z,
  output logic              flag_cy,
  output logic              flag_sign,
  output logic              done,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 1 << REG_AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_WB
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   regs [NREG];
  logic [3:0]          opc_q;
  logic [REG_AW-1:0]   rd_q;
  logic [REG_AW-1:0]   rs_q;
  logic [DATA_W-1:0]   imm_q;
  logic                use_imm_q;
  logic                wb_q;

  assign dbg_data = regs[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      opc_q         <= '0;
      rd_q          <= '0;
      rs_q          <= '0;
      imm_q         <= '0;
      use_imm_q     <= 1'b0;
      wb_q          <= 1'b0;
      alu_operand_1 <= '0;
      alu_operand_2 <= '0;
      alu_opcode    <= '0;
      flag_z        <= 1'b0;
      flag_cy       <= 1'b0;
      flag_sign     <= 1'b0;
      done          <= 1'b0;
      instr_ready   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          // instr_ready is high throughout IDLE, so valid alone completes the handshake
          if (instr_valid) begin
            opc_q       <= instr_opcode;
            rd_q        <= instr_rd;
            rs_q        <= instr_rs;
            imm_q       <= instr_imm;
            use_imm_q   <= instr_use_imm;
            wb_q        <= instr_wb;
            instr_ready <= 1'b0;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          alu_operand_1 <= regs[rd_q];
          alu_operand_2 <= use_imm_q ? imm_q : regs[rs_q];
          alu_opcode    <= opc_q;
          state         <= S_EXEC;
        end
        S_EXEC: begin
          if (wb_q) regs[rd_q] <= alu_out;
          flag_z    <= alu_z;
          flag_cy   <= alu_cy;
          flag_sign <= alu_sign;
          done      <= 1'b1;
          state     <= S_WB;
        end
        default: begin
          done        <= 1'b0;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
